// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encode_loader
// Description : Encodes RV32I R-type / load / store field bundles into 32-bit
//               instruction words and writes them sequentially into the
//               instruction memory through a valid/ready front end.
//               Optional checksum build: define ENC_LOADER_CSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encode_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       fmt_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [11:0]      imm_i,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_wdata_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             done_o,
    output logic             err_fmt_o,
    output logic             err_ovf_o,
    output logic [31:0]      csum_o
);

    // Count value that, once incremented by a legal write, reaches MAX_WORDS
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       ptr_q;        // address the next legal word goes to
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_fmt_q;
    logic              err_ovf_q;

    logic              w_xfer;
    logic              w_legal;
    logic              w_illegal;
    logic [31:0]       w_enc;

    assign in_ready_o = (state_q == S_LOAD) && !start_i;
    assign w_xfer     = in_valid_i && in_ready_o;
    assign w_illegal  = w_xfer && (fmt_i == 2'd3);
    assign w_legal    = w_xfer && (fmt_i != 2'd3);

    // Build the instruction word for the presented format
    always_comb begin
        w_enc = 32'h0;
        case (fmt_i)
            2'd0:    w_enc = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'h33};
            2'd1:    w_enc = {imm_i, rs1_i, funct3_i, rd_i, 7'h03};
            2'd2:    w_enc = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'h23};
            default: w_enc = 32'h0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: START wins over everything; STOP wins over reaching FULL
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: begin
                if (start_i)                           state_d = S_LOAD;
                else if (stop_i)                       state_d = S_IDLE;
                else if (w_legal && (cnt_q == C_LAST)) state_d = S_FULL;
            end
            S_FULL: if (start_i) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Write port, address pointer, word count and sticky errors
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= 32'h0;
            ptr_q     <= BASE_ADDR;
            cnt_q     <= '0;
            err_fmt_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            we_q <= w_legal;
            if (start_i) begin
                ptr_q     <= BASE_ADDR;
                cnt_q     <= '0;
                err_fmt_q <= 1'b0;
                err_ovf_q <= 1'b0;
            end else begin
                if (w_legal) begin
                    addr_q  <= ptr_q;
                    wdata_q <= w_enc;
                    ptr_q   <= ptr_q + 32'd4;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                if (w_illegal) err_fmt_q <= 1'b1;
                if ((state_q == S_FULL) && in_valid_i) err_ovf_q <= 1'b1;
            end
        end
    end

`ifdef ENC_LOADER_CSUM_EN
    logic [31:0] csum_q;

    // XOR of every word written since START, visible alongside its write strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     csum_q <= 32'h0;
        else if (start_i) csum_q <= 32'h0;
        else if (w_legal) csum_q <= csum_q ^ w_enc;
    end

    assign csum_o = csum_q;
`else
    assign csum_o = 32'h0;
`endif

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_cnt_o   = cnt_q;
    assign done_o       = (state_q == S_FULL);
    assign err_fmt_o    = err_fmt_q;
    assign err_ovf_o    = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encode_loader
// Description : Directed plus randomized bench for instr_encode_loader with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encode_loader;

    localparam logic [31:0] C_BASE = 32'h0000_0000;
    localparam int          C_MAX  = 4;
    localparam int          C_CW   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0, stop = 1'b0, in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      fmt = 2'd0;
    logic [4:0]      rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]      funct3 = '0;
    logic [6:0]      funct7 = '0;
    logic [11:0]     imm = '0;
    logic            imem_we;
    logic [31:0]     imem_addr, imem_wdata, csum;
    logic [C_CW-1:0] word_cnt;
    logic            done, err_fmt, err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: mode 0 = idle, 1 = loading, 2 = full
    int          m_mode;
    logic [31:0] m_ptr;
    int          m_cnt;
    logic        m_errf, m_erro;
    logic [31:0] m_csum;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;

    instr_encode_loader #(
        .BASE_ADDR (C_BASE),
        .MAX_WORDS (C_MAX),
        .CNT_W     (C_CW)
    ) u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .fmt_i        (fmt),
        .rd_i         (rd),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .funct3_i     (funct3),
        .funct7_i     (funct7),
        .imm_i        (imm),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .word_cnt_o   (word_cnt),
        .done_o       (done),
        .err_fmt_o    (err_fmt),
        .err_ovf_o    (err_ovf),
        .csum_o       (csum)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Field arithmetic straight from the RV32I format tables
    function automatic logic [31:0] encode(input int f);
        int unsigned w;
        case (f)
            0: w = (int'(funct7) << 25) | (int'(rs2) << 20) | (int'(rs1) << 15)
                 | (int'(funct3) << 12) | (int'(rd) << 7) | 'h33;
            1: w = (int'(imm) << 20) | (int'(rs1) << 15) | (int'(funct3) << 12)
                 | (int'(rd) << 7) | 'h03;
            default: w = ((int'(imm) / 32) << 25) | (int'(rs2) << 20) | (int'(rs1) << 15)
                 | (int'(funct3) << 12) | ((int'(imm) % 32) << 7) | 'h23;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ptr = C_BASE; m_cnt = 0; m_errf = 0; m_erro = 0;
        m_csum = 0; e_we = 0; e_addr = C_BASE; e_wdata = 0;
    endtask

    task automatic check_all();
        check_eq("ready",   {31'd0, in_ready}, {31'd0, (m_mode == 1) && !start});
        check_eq("we",      {31'd0, imem_we},  {31'd0, e_we});
        check_eq("addr",    imem_addr,  e_addr);
        check_eq("wdata",   imem_wdata, e_wdata);
        check_eq("cnt",     32'(word_cnt), m_cnt);
        check_eq("done",    {31'd0, done},    {31'd0, m_mode == 2});
        check_eq("err_fmt", {31'd0, err_fmt}, {31'd0, m_errf});
        check_eq("err_ovf", {31'd0, err_ovf}, {31'd0, m_erro});
`ifdef ENC_LOADER_CSUM_EN
        check_eq("csum", csum, m_csum);
`else
        check_eq("csum", csum, 32'h0);
`endif
    endtask

    // One clock: drive controls (fields already set), predict, then check
    task automatic step(input logic st, input logic sp, input logic v);
        int   old_mode;
        logic xfer;
        @(negedge clk);
        start = st; stop = sp; in_valid = v;
        #1;
        check_eq("ready_pre", {31'd0, in_ready}, {31'd0, (m_mode == 1) && !st});
        old_mode = m_mode;
        xfer = v && (m_mode == 1) && !st;
        e_we = 0;
        if (st) begin
            m_mode = 1; m_ptr = C_BASE; m_cnt = 0; m_errf = 0; m_erro = 0; m_csum = 0;
        end else begin
            if (old_mode == 2 && v) m_erro = 1;
            if (xfer) begin
                if (fmt == 2'd3) m_errf = 1;
                else begin
                    e_we = 1; e_addr = m_ptr; e_wdata = encode(int'(fmt));
                    m_ptr = m_ptr + 4; m_cnt++; m_csum ^= e_wdata;
                    if (m_cnt == C_MAX) m_mode = 2;
                end
            end
            if (old_mode == 1 && sp) m_mode = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [11:0] im);
        fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 0; stop = 0; in_valid = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single load word
        step(1, 0, 0);
        set_fields(2'd1, 5'd6, 5'd9, 5'd0, 3'd2, 7'd0, 12'hFFC);
        step(0, 0, 1);
        check_eq("tp_load_wdata", imem_wdata, 32'hFFC4A303);
        check_eq("tp_load_addr",  imem_addr,  32'h0);

        // Back-to-back store then R-type
        step(1, 0, 0);
        set_fields(2'd2, 5'd0, 5'd9, 5'd6, 3'd2, 7'd0, 12'd8);
        step(0, 0, 1);
        check_eq("tp_store", imem_wdata, 32'h0064A423);
        set_fields(2'd0, 5'd4, 5'd5, 5'd6, 3'd6, 7'd0, 12'd0);
        step(0, 0, 1);
        check_eq("tp_rtype", imem_wdata, 32'h0062E233);
        check_eq("tp_raddr", imem_addr,  32'h4);
        step(0, 0, 0);

        // Fill to FULL, then overflow attempt, then START clears
        step(1, 0, 0);
        for (int i = 0; i < C_MAX + 1; i++) begin
            set_fields(2'd1, 5'(i + 1), 5'd2, 5'd3, 3'd2, 7'd0, 12'(i * 4));
            step(0, 0, 1);
        end
        step(0, 0, 0);
        step(1, 0, 0);

        // Illegal format between two legal loads
        set_fields(2'd1, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 12'h10);
        step(0, 0, 1);
        set_fields(2'd3, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 12'hFFF);
        step(0, 0, 1);
        set_fields(2'd1, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 12'h20);
        step(0, 0, 1);
        check_eq("tp_fmt_addr", imem_addr, 32'h4);

        // START and STOP together, then STOP with a transfer
        step(1, 1, 0);
        step(0, 1, 1);
        step(0, 0, 1);

        // Reset shortly after a transfer
        step(1, 0, 0);
        step(0, 0, 1);
        do_reset();
        step(0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            set_fields(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                       5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                       7'($urandom), 12'($urandom));
            step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 75);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Encodes RV32I instruction fields (R-type 0x33, load 0x03, store 0x23) into 32-bit words and writes them sequentially into instruction memory. It is the encode/write-side counterpart of the core's opcode decode path. Bench and boot logic use it to load programs through a valid/ready interface. It sits between a program source (testbench or boot ROM sequencer) and the instruction memory write port.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of first instruction word written after START
MAX_WORDS, 64, number of words accepted before entering FULL (range 1..65535)
CNT_W, 16, width of WORD_CNT

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  pulse: clear address/count/errors, enter LOAD
STOP  input  1  pulse: LOAD -> IDLE
IN_VALID  input  1  field bundle valid
IN_READY  output  1  block accepts bundle this cycle
FMT  input  2  0=R-type, 1=load, 2=store, 3=illegal
RD  input  5  destination register
RS1  input  5  source register 1
RS2  input  5  source register 2
FUNCT3  input  3  funct3 field
FUNCT7  input  7  funct7 field (R-type only)
IMM  input  12  immediate (load/store)
IMEM_WE  output  1  one-cycle instruction-memory write strobe
IMEM_ADDR  output  32  write byte address
IMEM_WDATA  output  32  encoded instruction
WORD_CNT  output  CNT_W  words written since START
DONE  output  1  high in FULL state
ERR_FMT  output  1  sticky: illegal FMT accepted
ERR_OVF  output  1  sticky: IN_VALID seen while FULL
CSUM  output  32  running checksum (see Optional Feature)

Behaviour:
- Reset (RST_N low, async): state IDLE; IN_READY, IMEM_WE, DONE, ERR_FMT, ERR_OVF = 0; IMEM_ADDR = BASE_ADDR; IMEM_WDATA, WORD_CNT, CSUM = 0. Reset mid-load aborts with no further writes.
- States: IDLE, LOAD, FULL.
  - IDLE -> LOAD on START.
  - LOAD -> LOAD on START (restart).
  - LOAD -> IDLE on STOP and no START.
  - LOAD -> FULL when a legal write brings the count to MAX_WORDS.
  - FULL -> LOAD on START.
  - START beats STOP when both are asserted.
- START clears the next-address pointer to BASE_ADDR and clears WORD_CNT, ERR_FMT, ERR_OVF and CSUM.
- IN_READY = (state==LOAD) && !START, combinational. A transfer happens when IN_VALID && IN_READY.
- Encoding (FUNCT3 in [14:12] for all formats):
  - R: {FUNCT7, RS2, RS1, FUNCT3, RD, 7'h33}
  - Load: {IMM[11:0], RS1, FUNCT3, RD, 7'h03}
  - Store: {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], 7'h23}
  - Unused fields are ignored.
- Latency: transfer in cycle N -> IMEM_WE=1 in cycle N+1 with registered IMEM_ADDR/IMEM_WDATA. IMEM_WE is high exactly one cycle per legal transfer.
- Throughput is one word per cycle; back-to-back transfers produce consecutive writes.
- After each legal write: address += 4 (32-bit wrap, no error) and WORD_CNT += 1.
- Illegal FMT=3: the handshake completes, no write, no address/count change, ERR_FMT set.
- FULL: IN_READY=0, DONE=1. IN_VALID high for any cycle sets ERR_OVF. The final write still issues in the cycle after the transfer.
- A transfer in the same cycle as STOP is accepted and written; the state then goes to IDLE.
- IMEM_ADDR/IMEM_WDATA hold their last values when IMEM_WE=0.

Optional Feature:
- Macro ENC_LOADER_CSUM_EN.
- Defined: CSUM = XOR of all IMEM_WDATA values written since START, updated in the same cycle as IMEM_WE.
- Undefined: CSUM tied to 32'h0 and the checksum logic is absent. The port exists in both builds.

Test Plan:
- Reset, START, load FMT=1 RD=6 RS1=9 FUNCT3=2 IMM=12'hFFC -> next cycle IMEM_WE=1, ADDR=0x0, WDATA=0xFFC4A303, WORD_CNT=1.
- Back-to-back store (RS2=6 RS1=9 FUNCT3=2 IMM=8) then R-type (FUNCT7=0 RS2=6 RS1=5 FUNCT3=6 RD=4) -> WDATA 0x0064A423 @0x0, then 0x0062E233 @0x4, on consecutive cycles; CSUM (macro on) = 0x0064A423^0x0062E233.
- MAX_WORDS=2, send 3 bundles -> two writes, DONE=1, IN_READY=0, third IN_VALID sets ERR_OVF=1; START then clears DONE, ERR_OVF and WORD_CNT.
- FMT=3 between two legal loads -> ERR_FMT=1, legal writes at 0x0 and 0x4 with no gap in addresses, WORD_CNT=2.
- START and STOP asserted together in LOAD -> remains LOAD, address back to BASE_ADDR. STOP alone with IN_VALID -> that word is written, then IDLE with IN_READY=0.
- RST_N low one cycle after a transfer -> no IMEM_WE pulse, all outputs at reset values.
